// File: rtl/alu_chk_pkg.sv
// rtl/alu_chk_pkg.sv - shared types and vector field layout for the ALU self-test checker
// Purpose: vector width, bit offsets of each packed vector field, FSM state type and
//          a structured view of one test vector.
// Vector layout, MSB first: {eC, eN, eV, eZ, F[1:0], A[31:0], B[31:0], eY[31:0]}.
// Ports: none (package).
package alu_chk_pkg;

    localparam int EY_LSB = 0;
    localparam int B_LSB  = 32;
    localparam int A_LSB  = 64;
    localparam int F_LSB  = 96;
    localparam int EZ_BIT = 98;
    localparam int EV_BIT = 99;
    localparam int EN_BIT = 100;
    localparam int EC_BIT = 101;
    // Four flag bits, a 2-bit function code and three 32-bit words.
    localparam int VEC_W  = 102;
    // Compared result: {Y, Z, V, N, C}.
    localparam int RES_W  = 36;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        APPLY,
        CHECK,
        DONE
    } chk_state_t;

    typedef struct packed {
        logic        ec;
        logic        en;
        logic        ev;
        logic        ez;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ey;
    } vec_t;

endpackage

// File: rtl/alu_chk_cmp.sv
// rtl/alu_chk_cmp.sv - combinational expected-versus-actual result comparator
// Purpose: flags any difference across the full {Y, Z, V, N, C} result word.
// Ports:
//   i_exp       in  36  expected {Y, Z, V, N, C}
//   i_act       in  36  observed {Y, Z, V, N, C}
//   o_mismatch  out 1   high when any bit differs
module alu_chk_cmp
    import alu_chk_pkg::*;
(
    input  logic [RES_W-1:0] i_exp,
    input  logic [RES_W-1:0] i_act,
    output logic             o_mismatch
);

    assign o_mismatch = (i_exp != i_act);

endmodule

// File: rtl/alu_vector_checker.sv
// rtl/alu_vector_checker.sv - on-chip BIST sequencer that replays ROM vectors through alu32
// Purpose: fetches packed vectors, drives registered A/B/F into the ALU, compares the ALU
//          result and flags against the vector's expectations, counts checked and failing
//          vectors. Three cycles per vector (FETCH, APPLY, CHECK).
// Optional build macro: ALU_CHK_FAILCAP_EN adds first-failure capture outputs.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, num_vectors    run request and run length (0..2**ADDR_W), sampled on accept
//   vec_addr, vec_rd      ROM read address / enable (data returns next cycle)
//   vec_data              packed vector from ROM
//   alu_a, alu_b, alu_f   registered ALU operands and function
//   alu_y, alu_zero, alu_ovf, alu_neg, alu_carry   ALU result and flags
//   busy, done            run in progress / run complete (level)
//   err_count, vec_count  failing (saturating) and checked vector counts
//   fail_valid, fail_index, fail_y, fail_flags     first failure ({C,N,V,Z}), macro only
module alu_vector_checker
    import alu_chk_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vectors,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              vec_rd,
    input  logic [VEC_W-1:0]  vec_data,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [1:0]        alu_f,
    input  logic [31:0]       alu_y,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    input  logic              alu_neg,
    input  logic              alu_carry,
`ifdef ALU_CHK_FAILCAP_EN
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_index,
    output logic [31:0]       fail_y,
    output logic [3:0]        fail_flags,
`endif
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W:0]   vec_count
);

    chk_state_t        r_state;
    chk_state_t        w_next;
    logic              w_vec_rd;
    logic              w_accept;
    logic              w_last;
    logic              w_mismatch;
    logic [ADDR_W:0]   w_count_inc;
    logic [RES_W-1:0]  w_act;

    logic [ADDR_W:0]   r_num;
    logic [ADDR_W-1:0] r_index;
    logic [ADDR_W:0]   r_vec_count;
    logic [ERR_W-1:0]  r_err;
    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [1:0]        r_f;
    logic [RES_W-1:0]  r_exp;

    // r_busy also covers the single cycle spent in DONE after a zero-length run,
    // so a start arriving in that cycle is ignored like any other busy start.
    assign w_accept    = start && !r_busy && ((r_state == IDLE) || (r_state == DONE));
    assign w_count_inc = r_vec_count + 1'b1;
    // Compared in ADDR_W+1 bits so a full 2**ADDR_W run ends on the last address
    // without the index ever wrapping.
    assign w_last      = (w_count_inc == r_num);
    assign w_act       = {alu_y, alu_zero, alu_ovf, alu_neg, alu_carry};

    alu_chk_cmp u_cmp (
        .i_exp      (r_exp),
        .i_act      (w_act),
        .o_mismatch (w_mismatch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_vec_rd = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_next = (num_vectors == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                w_vec_rd = 1'b1;
                w_next   = APPLY;
            end
            APPLY: begin
                w_next = CHECK;
            end
            CHECK: begin
                w_next = w_last ? DONE : FETCH;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

`ifdef ALU_CHK_FAILCAP_EN
    logic              r_fail_valid;
    logic [ADDR_W-1:0] r_fail_index;
    logic [31:0]       r_fail_y;
    logic [3:0]        r_fail_flags;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num        <= '0;
            r_index      <= '0;
            r_vec_count  <= '0;
            r_err        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_f          <= '0;
            r_exp        <= '0;
`ifdef ALU_CHK_FAILCAP_EN
            r_fail_valid <= 1'b0;
            r_fail_index <= '0;
            r_fail_y     <= '0;
            r_fail_flags <= '0;
`endif
        end else if (w_accept) begin
            r_num        <= num_vectors;
            r_index      <= '0;
            r_vec_count  <= '0;
            r_err        <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
`ifdef ALU_CHK_FAILCAP_EN
            r_fail_valid <= 1'b0;
            r_fail_index <= '0;
            r_fail_y     <= '0;
            r_fail_flags <= '0;
`endif
        end else begin
            case (r_state)
                APPLY: begin
                    r_a   <= vec_data[A_LSB +: 32];
                    r_b   <= vec_data[B_LSB +: 32];
                    r_f   <= vec_data[F_LSB +: 2];
                    r_exp <= {vec_data[EY_LSB +: 32], vec_data[EZ_BIT], vec_data[EV_BIT],
                              vec_data[EN_BIT], vec_data[EC_BIT]};
                end
                CHECK: begin
                    r_vec_count <= w_count_inc;
                    if (w_mismatch && (r_err != '1)) begin
                        r_err <= r_err + 1'b1;
                    end
`ifdef ALU_CHK_FAILCAP_EN
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_index <= r_index;
                        r_fail_y     <= alu_y;
                        r_fail_flags <= {alu_carry, alu_neg, alu_ovf, alu_zero};
                    end
`endif
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign vec_addr  = r_index;
    assign vec_rd    = w_vec_rd;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_f     = r_f;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_count = r_err;
    assign vec_count = r_vec_count;
`ifdef ALU_CHK_FAILCAP_EN
    assign fail_valid = r_fail_valid;
    assign fail_index = r_fail_index;
    assign fail_y     = r_fail_y;
    assign fail_flags = r_fail_flags;
`endif

endmodule

// File: tb/tb_alu_vector_checker.sv
// tb/tb_alu_vector_checker.sv - scoreboard bench for alu_vector_checker with an alu32 model
module tb_alu_vector_checker;

    localparam int ADDR_W  = 8;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   num_vectors;
    logic [ADDR_W-1:0] vec_addr;
    logic              vec_rd;
    logic [101:0]      vec_data;
    logic [31:0]       alu_a, alu_b, alu_y;
    logic [1:0]        alu_f;
    logic              alu_zero, alu_ovf, alu_neg, alu_carry;
    logic              busy, done;
    logic [ERR_W-1:0]  err_count;
    logic [ADDR_W:0]   vec_count;
`ifdef ALU_CHK_FAILCAP_EN
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_index;
    logic [31:0]       fail_y;
    logic [3:0]        fail_flags;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_vector_checker #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
        .vec_addr(vec_addr), .vec_rd(vec_rd), .vec_data(vec_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_neg(alu_neg), .alu_carry(alu_carry),
`ifdef ALU_CHK_FAILCAP_EN
        .fail_valid(fail_valid), .fail_index(fail_index), .fail_y(fail_y),
        .fail_flags(fail_flags),
`endif
        .busy(busy), .done(done), .err_count(err_count), .vec_count(vec_count)
    );

    // alu32 reference: 00 AND, 01 OR, 10 ADD, 11 SUB; result packed {Y, Z, V, N, C}.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] f);
        logic [32:0] s;
        logic [31:0] y;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (f)
            2'b00: y = a & b;
            2'b01: y = a | b;
            2'b10: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            default: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                y = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
        endcase
        return {y, (y == 32'd0), v, y[31], c};
    endfunction

    logic [35:0] alu_res;
    always_comb alu_res = alu_ref(alu_a, alu_b, alu_f);
    assign alu_y     = alu_res[35:4];
    assign alu_zero  = alu_res[3];
    assign alu_ovf   = alu_res[2];
    assign alu_neg   = alu_res[1];
    assign alu_carry = alu_res[0];

    logic [101:0] rom [0:255];
    always @(posedge clk) if (vec_rd) vec_data <= rom[vec_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected fields of a vector are the true ALU result XOR a corruption mask.
    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] f, input logic [35:0] mask);
        logic [35:0] e;
        e = alu_ref(a, b, f) ^ mask;
        rom[i] = {e[0], e[1], e[2], e[3], f, a, b, e[35:4]};
    endtask

    typedef struct {
        int          n;
        int          err;
        int          cycles;
        logic [31:0] la, lb;
        logic [1:0]  lf;
        logic        fv;
        int          fidx;
        logic [31:0] fy;
        logic [3:0]  ff;
    } exp_t;

    exp_t        q[$];
    logic [31:0] held_a = '0, held_b = '0;
    logic [1:0]  held_f = '0;

    task automatic push_expect(input int n);
        exp_t        e;
        logic [101:0] v;
        logic [35:0] want, got;
        e = '{n: n, err: 0, cycles: (n == 0) ? 1 : 3 * n, la: 0, lb: 0, lf: 0,
              fv: 0, fidx: 0, fy: 0, ff: 0};
        for (int i = 0; i < n; i++) begin
            v    = rom[i];
            want = {v[31:0], v[98], v[99], v[100], v[101]};
            got  = alu_ref(v[95:64], v[63:32], v[97:96]);
            if (want != got) begin
                if (e.err < ERR_MAX) e.err++;
                if (!e.fv) begin
                    e.fv   = 1'b1;
                    e.fidx = i;
                    e.fy   = got[35:4];
                    e.ff   = {got[0], got[1], got[2], got[3]};
                end
            end
            held_a = v[95:64];
            held_b = v[63:32];
            held_f = v[97:96];
        end
        e.la = held_a;
        e.lb = held_b;
        e.lf = held_f;
        q.push_back(e);
    endtask

    task automatic run(input int n, input int poke);
        int c;
        push_expect(n);
        @(negedge clk);
        num_vectors = n[ADDR_W:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_vectors = 9'($urandom_range(0, 511));
        c = 0;
        while (!done && c < 3 * n + 20) begin
            @(negedge clk);
            start = (c == poke);
            c++;
        end
        start = 1'b0;
        if (!done) begin
            chk("run_timeout", 64'(n), 64'hffff_ffff);
            q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: scores each completed run against the next queued expectation.
    int   busy_cyc = 0;
    int   rd_idx = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cyc  = 0;
            rd_idx    = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_cyc++;
            if (vec_rd) begin
                chk("vec_addr", 64'(vec_addr), 64'(rd_idx));
                rd_idx++;
            end
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("err_count", 64'(err_count), 64'(e.err));
                    chk("vec_count", 64'(vec_count), 64'(e.n));
                    chk("busy_cycles", 64'(busy_cyc), 64'(e.cycles));
                    chk("rom_reads", 64'(rd_idx), 64'(e.n));
                    chk("busy_at_done", 64'(busy), 64'd0);
                    chk("alu_a_hold", 64'(alu_a), 64'(e.la));
                    chk("alu_b_hold", 64'(alu_b), 64'(e.lb));
                    chk("alu_f_hold", 64'(alu_f), 64'(e.lf));
`ifdef ALU_CHK_FAILCAP_EN
                    chk("fail_valid", 64'(fail_valid), 64'(e.fv));
                    chk("fail_index", 64'(fail_index), 64'(e.fidx));
                    chk("fail_y", 64'(fail_y), 64'(e.fy));
                    chk("fail_flags", 64'(fail_flags), 64'(e.ff));
`endif
                end
                busy_cyc = 0;
                rd_idx   = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) rom[i] = '0;
        rst_n = 1'b0;
        start = 1'b0;
        num_vectors = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_vcnt", 64'(vec_count), 64'd0);
        chk("rst_addr", 64'(vec_addr), 64'd0);
        chk("rst_alu", 64'({alu_a, alu_b, alu_f}), 64'd0);
        rst_n = 1'b1;

        run(0, -1);

        set_vec(0, 32'd5, 32'd3, 2'b10, 36'd0);
        run(1, -1);

        set_vec(0, 32'h1234, 32'h00ff, 2'b00, 36'd0);
        set_vec(1, 32'hf0f0_0000, 32'h0000_0f0f, 2'b01, 36'd0);
        set_vec(2, 32'd0, 32'd1, 2'b10, {32'h1, 4'h0});
        set_vec(3, 32'd9, 32'd9, 2'b11, 36'd0);
        run(4, -1);

        set_vec(0, 32'h7fff_ffff, 32'd1, 2'b10, 36'd0);
        run(1, -1);
        set_vec(0, 32'h7fff_ffff, 32'd1, 2'b10, 36'd1);
        run(1, -1);

        for (int i = 0; i < 5; i++) set_vec(i, $urandom, $urandom, 2'($urandom), 36'd0);
        run(5, 4);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
                set_vec(i, a, b, 2'($urandom),
                        ($urandom_range(0, 3) == 0) ? (36'd1 << $urandom_range(0, 35)) : 36'd0);
            end
            run(n, -1);
        end

        for (int i = 0; i < 10; i++) set_vec(i, $urandom, $urandom, 2'($urandom), 36'h8_0000_0000);
        @(negedge clk);
        num_vectors = 9'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_err_nonzero", 64'(err_count != '0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_err", 64'(err_count), 64'd0);
        chk("abort_vcnt", 64'(vec_count), 64'd0);
        chk("abort_addr", 64'(vec_addr), 64'd0);
        chk("abort_alu", 64'({alu_a, alu_b, alu_f}), 64'd0);
        held_a = '0;
        held_b = '0;
        held_f = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++)
            set_vec(i, $urandom, $urandom, 2'($urandom), 36'd1 << $urandom_range(0, 35));
        run(256, -1);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
